// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
//   Round-robin arbiter that shares one synchronous FIFO push port among N_REQ
//   valid/ready requesters. A requester that wins arbitration keeps the port for
//   up to MAX_BURST consecutive beats. The owner releases the lock early if it
//   drops valid. No push is issued while the FIFO reports full.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   req_valid_i  per-requester valid
//   req_data_i   requester k data at [k*DATA_W +: DATA_W]
//   req_ready_o  per-requester ready (at most one set; beat moves on valid&ready)
//   push_o       FIFO push strobe (combinational, same cycle as the handshake)
//   push_data_o  FIFO push data (0 when no push)
//   full_i       FIFO full flag
//   grant_vld_o  burst lock currently held
//   grant_id_o   owner of the lock, 0 when not locked
// -----------------------------------------------------------------------------
module fifo_push_arbiter #(
  parameter  int DATA_W    = 8,
  parameter  int N_REQ     = 4,
  parameter  int MAX_BURST = 4,
  localparam int ID_W      = $clog2(N_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    push_o,
  output logic [DATA_W-1:0]       push_data_o,
  input  logic                    full_i,
  output logic                    grant_vld_o,
  output logic [ID_W-1:0]         grant_id_o
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e             state_q,    state_d;
  logic [ID_W-1:0]    rr_ptr_q,   rr_ptr_d;
  logic [ID_W-1:0]    owner_q,    owner_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]    win_idx;
  logic               win_found;

  // Successor index with explicit wrap, so non-power-of-2 N_REQ stays in range.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
    return (idx == ID_W'(N_REQ - 1)) ? '0 : idx + ID_W'(1);
  endfunction

  // Win search: first valid requester starting at rr_ptr and wrapping modulo
  // N_REQ. The sum is one bit wider so rr_ptr + i never overflows before wrap.
  always_comb begin
    logic [ID_W:0] sum;
    win_idx   = '0;
    win_found = 1'b0;
    sum       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      if (!win_found && req_valid_i[sum[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[ID_W-1:0];
      end
    end
  end

  // Next-state and handshake decode.
  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    req_ready_o = '0;

    if (reset) begin
      unique case (state_q)
        IDLE: begin
          if (win_found && !full_i) begin
            req_ready_o[win_idx] = 1'b1;
            if (MAX_BURST == 1) begin
              rr_ptr_d = next_idx(win_idx);
            end else begin
              state_d    = LOCK;
              owner_d    = win_idx;
              beat_cnt_d = CNT_W'(1);
            end
          end
        end
        LOCK: begin
          if (!req_valid_i[owner_q]) begin
            // Owner went quiet: release now; others compete from next cycle.
            state_d    = IDLE;
            rr_ptr_d   = next_idx(owner_q);
            beat_cnt_d = '0;
          end else if (!full_i) begin
            req_ready_o[owner_q] = 1'b1;
            if (beat_cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
              state_d    = IDLE;
              rr_ptr_d   = next_idx(owner_q);
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
          end
          // Owner valid but FIFO full: stall with lock and count held.
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Data mux: at most one ready bit, so selecting by ready is unambiguous.
  always_comb begin
    push_data_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_ready_o[k]) push_data_o = req_data_i[k*DATA_W +: DATA_W];
    end
  end

  assign push_o      = |req_ready_o;
  assign grant_vld_o = (state_q == LOCK);
  assign grant_id_o  = (state_q == LOCK) ? owner_q : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values seen before the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready_o));
  a_no_push_full: assert property (@(posedge clk) !(push_o && full_i));

endmodule
